// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: sample FIFO, SCK divider and MSB-first serializer with
// standard one-bit WS lead. Sticky underrun flag for the register block.
module i2s_tx_serializer #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SCK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rf_i2so_en,
    input  logic              filt_rts,
    input  logic [DATA_W-1:0] filt_data,
    output logic              filt_rtr,
    output logic              i2so_sck,
    output logic              i2so_ws,
    output logic              i2so_sd,
    input  logic              trig_fifo_underrun_clr,
    output logic              ro_fifo_underrun
);
    localparam int unsigned SLOT_N = 2 * DATA_W;
    localparam int unsigned SLOT_W = $clog2(SLOT_N);
    localparam int unsigned DIV_W  = $clog2(SCK_DIV);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DIV_W-1:0]  div_q;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [DATA_W-1:0] shreg_q;

    logic              push_c, pop_req_c, pop_ok_c, fall_c, div_wrap_c, fifo_empty_c;
    logic [DATA_W-1:0] pop_word_c;

    assign div_wrap_c   = (div_q == DIV_W'(SCK_DIV - 1));
    assign fifo_empty_c = (count_q == '0);
    assign push_c       = filt_rts & filt_rtr;
    assign pop_ok_c     = pop_req_c & ~fifo_empty_c;
    assign pop_word_c   = pop_ok_c ? mem[rd_ptr_q] : '0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, slot advance and pop requests (left on slot 0, right on slot DATA_W)
    always_comb begin
        state_d   = state_q;
        pop_req_c = 1'b0;
        fall_c    = 1'b0;
        slot_d    = slot_q;
        case (state_q)
            ST_IDLE: begin
                if (rf_i2so_en) begin
                    state_d   = ST_RUN;
                    pop_req_c = 1'b1;
                    slot_d    = '0;
                end
            end
            ST_RUN: begin
                if (!rf_i2so_en) begin
                    state_d = ST_IDLE;
                    slot_d  = '0;
                end else if (div_wrap_c && i2so_sck) begin
                    fall_c    = 1'b1;
                    slot_d    = (slot_q == SLOT_W'(SLOT_N - 1)) ? '0 : slot_q + SLOT_W'(1);
                    pop_req_c = (slot_d == '0) || (slot_d == SLOT_W'(DATA_W));
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        count_d = count_q;
        if (push_c && !pop_ok_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_c && pop_ok_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            filt_rtr <= 1'b1;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q  <= count_d;
            filt_rtr <= (count_d != CNT_W'(FIFO_DEPTH));
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= filt_data;
        end
    end

    // SCK divider, slot counter and shift register; all forced to 0 when disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            slot_q   <= '0;
            shreg_q  <= '0;
            i2so_sck <= 1'b0;
            i2so_ws  <= 1'b0;
            i2so_sd  <= 1'b0;
        end else if (!rf_i2so_en) begin
            div_q    <= '0;
            slot_q   <= '0;
            shreg_q  <= '0;
            i2so_sck <= 1'b0;
            i2so_ws  <= 1'b0;
            i2so_sd  <= 1'b0;
        end else begin
            div_q  <= div_wrap_c ? '0 : div_q + DIV_W'(1);
            slot_q <= slot_d;
            if (div_wrap_c) begin
                i2so_sck <= ~i2so_sck;
            end
            if (pop_req_c) begin
                i2so_sd <= pop_word_c[DATA_W-1];
                shreg_q <= {pop_word_c[DATA_W-2:0], 1'b0};
            end else if (fall_c) begin
                i2so_sd <= shreg_q[DATA_W-1];
                shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
            end
            if (fall_c) begin
                i2so_ws <= (slot_d >= SLOT_W'(DATA_W - 1)) && (slot_d <= SLOT_W'(SLOT_N - 2));
            end
        end
    end

    // Sticky underrun flag; a new underrun beats a coincident clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ro_fifo_underrun <= 1'b0;
        end else if (pop_req_c && fifo_empty_c) begin
            ro_fifo_underrun <= 1'b1;
        end else if (trig_fifo_underrun_clr) begin
            ro_fifo_underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Scoreboard bench for i2s_tx_serializer: pushed words are queued and
// compared against words decoded from sd on SCK rising edges.
module tb_i2s_tx_serializer;
    localparam int unsigned DW    = 32;
    localparam int unsigned DIV   = 4;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic          rts = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] data = '0;
    logic          rtr, sck, ws, sd, flag;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_q[$];
    int            cyc = 0;
    int            words_seen = 0;
    int            mon_slot = 0;
    int            pushes = 0;

    logic          prev_sck = 1'b0;
    logic          first_rise = 1'b1;
    int            last_rise = 0;
    logic [DW-1:0] acc = '0;

    i2s_tx_serializer #(
        .DATA_W(DW),
        .SCK_DIV(DIV),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rf_i2so_en(en),
        .filt_rts(rts),
        .filt_data(data),
        .filt_rtr(rtr),
        .i2so_sck(sck),
        .i2so_ws(ws),
        .i2so_sd(sd),
        .trig_fifo_underrun_clr(clr),
        .ro_fifo_underrun(flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Serial decoder: samples sd/ws on each SCK rising edge
    always @(negedge clk) begin
        logic [DW-1:0] w;
        if (!rst_n || !en) begin
            mon_slot   = 0;
            prev_sck   = 1'b0;
            first_rise = 1'b1;
            acc        = '0;
        end else begin
            if (sck && !prev_sck) begin
                if (!first_rise) check("sck_period", cyc - last_rise, 2 * DIV);
                first_rise = 1'b0;
                last_rise  = cyc;
                check("ws_slot", ws, (mon_slot >= DW - 1 && mon_slot <= 2 * DW - 2) ? 1 : 0);
                acc = {acc[DW-2:0], sd};
                if (mon_slot == DW - 1 || mon_slot == 2 * DW - 1) begin
                    if (exp_q.size() == 0) begin
                        check("sb_no_expected_word", 1, 0);
                    end else begin
                        w = exp_q.pop_front();
                        check((mon_slot == DW - 1) ? "left_word" : "right_word", acc, w);
                    end
                    words_seen++;
                end
                mon_slot = (mon_slot == 2 * DW - 1) ? 0 : mon_slot + 1;
            end
            prev_sck = sck;
        end
    end

    task automatic drive_push(input logic [DW-1:0] w);
        int guard = 0;
        rts  = 1'b1;
        data = w;
        @(negedge clk);
        while (!rtr && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!rtr) begin
            check("push_timeout", rtr, 1);
            rts = 1'b0;
        end else begin
            @(posedge clk);
            exp_q.push_back(w);
            pushes++;
            #1 rts = 1'b0;
        end
    endtask

    task automatic wait_words(input int n, input int budget);
        int target = words_seen + n;
        int g = 0;
        while (words_seen < target && g < budget) begin
            @(posedge clk);
            g++;
        end
        check("words_done", words_seen, target);
    endtask

    task automatic wait_slot(input int target, input int budget);
        int g = 0;
        while (mon_slot != target && g < budget) begin
            @(posedge clk);
            g++;
        end
        check("slot_reached", mon_slot, target);
    endtask

    initial begin
        int accepted;
        int g;
        logic [DW-1:0] drop_words[4];
        drop_words[0] = 32'h8000_0001;
        drop_words[1] = 32'hDEAD_BEEF;
        drop_words[2] = 32'h0F1E_2D3C;
        drop_words[3] = 32'hF00D_CAFE;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_sck", sck, 0);
        check("rst_ws", ws, 0);
        check("rst_sd", sd, 0);
        check("rst_rtr", rtr, 1);
        check("rst_underrun", flag, 0);

        // Basic frame
        @(posedge clk); #1;
        drive_push(32'hA5A5_0F0F);
        drive_push(32'h1234_5678);
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("sd_msb_at_start", sd, 1);
        check("sck_low_at_start", sck, 0);
        @(negedge clk);
        @(negedge clk);
        check("sck_low_before_rise", sck, 0);
        @(negedge clk);
        check("sck_first_rise", sck, 1);
        wait_words(2, 1200);
        #1 en = 1'b0;
        check("basic_no_underrun", flag, 0);

        // Backpressure while disabled
        @(posedge clk); #1;
        accepted = 0;
        rts = 1'b1;
        data = 32'hBEEF_0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rtr) begin
                exp_q.push_back(data);
                accepted++;
            end
            @(posedge clk); #1;
            data = 32'hBEEF_0000 + DW'(accepted);
        end
        rts = 1'b0;
        check("bp_accepted", accepted, DEPTH);
        check("bp_rtr_full", rtr, 0);
        en = 1'b1;
        @(negedge clk);
        check("bp_rtr_before_pop", rtr, 0);
        @(negedge clk);
        check("bp_rtr_after_pop", rtr, 1);
        wait_words(4, 2500);
        #1 en = 1'b0;
        check("bp_no_underrun", flag, 0);

        // Underrun on the right word
        @(posedge clk); #1;
        drive_push(32'hC3C3_3C3C);
        exp_q.push_back('0);
        en = 1'b1;
        wait_words(2, 1200);
        #1 en = 1'b0;
        check("underrun_set", flag, 1);
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        check("underrun_cleared", flag, 0);
        @(posedge clk); #1;
        en = 1'b1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        en = 1'b0;
        @(negedge clk);
        check("underrun_set_beats_clear", flag, 1);
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        check("underrun_cleared_again", flag, 0);

        // Enable drop at slot 40, then restart with a fresh left pop
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) drive_push(drop_words[i]);
        en = 1'b1;
        wait_slot(41, 1000);
        #1;
        check("drop_ws_before", ws, 1);
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("drop_sck_zero", sck, 0);
        check("drop_ws_zero", ws, 0);
        check("drop_sd_zero", sd, 0);
        void'(exp_q.pop_front());
        @(posedge clk); #1 en = 1'b1;
        wait_words(2, 1200);
        #1 en = 1'b0;
        check("drop_no_underrun", flag, 0);

        // Ramp stream at full rate
        @(posedge clk); #1;
        pushes = 0;
        fork
            for (int i = 0; i < 100; i++) drive_push(DW'(i));
        join_none
        g = 0;
        while (pushes < 4 && g < 100) begin
            @(posedge clk);
            g++;
        end
        #1 en = 1'b1;
        wait_words(100, 100 * 256 + 1000);
        #1 en = 1'b0;
        check("stream_pushes", pushes, 100);
        check("stream_no_underrun", flag, 0);
        check("stream_sb_drained", exp_q.size(), 0);

        // Async reset mid-frame; first left pop collides with a push on an empty FIFO
        @(posedge clk); #1;
        exp_q.push_back('0);
        en = 1'b1;
        drive_push(32'hFFFF_FFFF);
        drive_push(32'hFFFF_FFFF);
        wait_slot(41, 1000);
        #3;
        check("pre_reset_ws", ws, 1);
        check("pre_reset_sd", sd, 1);
        check("pre_reset_underrun", flag, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_sck", sck, 0);
        check("async_rst_ws", ws, 0);
        check("async_rst_sd", sd, 0);
        check("async_rst_rtr", rtr, 1);
        check("async_rst_underrun", flag, 0);
        exp_q.delete();
        en = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
